// File: rtl/ir_cmd_pkg.sv
// Shared types, default command codes, frame field positions and the LED action function
// for the IR LED command engine.
package ir_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam logic [7:0] DEF_CODE_SHR  = 8'h1B;
    localparam logic [7:0] DEF_CODE_SHL  = 8'h1F;
    localparam logic [7:0] DEF_CODE_INV  = 8'h1E;
    localparam logic [7:0] DEF_CODE_SWAP = 8'h0C;
    localparam logic [7:0] DEF_CODE_ROR  = 8'h1A;
    localparam logic [7:0] DEF_CODE_CLR  = 8'h12;

    localparam int FRM_NCMD_HI = 31;
    localparam int FRM_NCMD_LO = 24;
    localparam int FRM_CMD_HI  = 23;
    localparam int FRM_CMD_LO  = 16;
    localparam int FRM_EXT_HI  = 15;
    localparam int FRM_EXT_LO  = 8;
    localparam int FRM_ADDR_HI = 7;
    localparam int FRM_ADDR_LO = 0;

    typedef struct packed {
        logic [7:0] shr;
        logic [7:0] shl;
        logic [7:0] inv;
        logic [7:0] ror;
        logic [7:0] swp;
        logic [7:0] clr;
    } codes_t;

    typedef struct packed {
        logic [31:0] led;
        logic [31:0] save;
    } led_save_t;

    // Works on a 32-bit container; led/save must arrive zero-extended from 'width' bits.
    // The if/else order gives the decode priority when codes collide.
    function automatic led_save_t led_next(input codes_t codes, input int width,
                                           input logic [7:0] cmd,
                                           input logic [31:0] led, input logic [31:0] save);
        logic [31:0] msb;
        logic [31:0] mask;
        led_save_t   r;
        msb    = 32'd1 << (width - 1);
        mask   = (msb << 1) - 32'd1;
        r.led  = led;
        r.save = save;
        if (cmd == codes.shr) begin
            r.led = (led >> 1) | msb;
        end else if (cmd == codes.shl) begin
            r.led = (led << 1) & mask;
        end else if (cmd == codes.inv) begin
            r.led = ~led & mask;
        end else if (cmd == codes.ror) begin
            r.led = (led >> 1) | (led[0] ? msb : 32'd0);
        end else if (cmd == codes.swp) begin
            r.led  = save;
            r.save = (save == 32'd0) ? led : 32'd0;
        end else if (cmd == codes.clr) begin
            r.led  = 32'd0;
            r.save = 32'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/ir_frame_check.sv
// Ready edge detect, frame capture and integrity check for the IR LED command engine.
// Optional IR_ADDR_FILTER_EN additionally requires the address byte to equal DEV_ADDR.
module ir_frame_check
    import ir_cmd_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_ready_i,
    input  logic [31:0] ir_data_i,
    input  logic        capture_i,
    input  logic        check_i,
    output logic        start_o,
    output logic        frame_ok_o,
    output logic        frame_bad_o,
    output logic [7:0]  cmd_o
);

    logic        ready_q;
    logic [31:0] frame_q;
    logic        inv_ok;
    logic        addr_ok;
    logic        unused_bits;

    assign start_o = ir_ready_i & ~ready_q;

    // Frames arriving while the controller is busy are simply not captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            frame_q <= 32'd0;
        end else begin
            ready_q <= ir_ready_i;
            if (start_o && capture_i) begin
                frame_q <= ir_data_i;
            end
        end
    end

    assign cmd_o  = frame_q[FRM_CMD_HI:FRM_CMD_LO];
    assign inv_ok = (frame_q[FRM_NCMD_HI:FRM_NCMD_LO] == ~frame_q[FRM_CMD_HI:FRM_CMD_LO]);

`ifdef IR_ADDR_FILTER_EN
    assign addr_ok     = (frame_q[FRM_ADDR_HI:FRM_ADDR_LO] == DEV_ADDR);
    assign unused_bits = ^frame_q[FRM_EXT_HI:FRM_EXT_LO];
`else
    assign addr_ok     = 1'b1;
    assign unused_bits = ^{frame_q[FRM_EXT_HI:FRM_ADDR_LO], DEV_ADDR};
`endif

    // An address mismatch is a silent drop; only a broken inverse counts as an error.
    assign frame_ok_o  = check_i & inv_ok & addr_ok;
    assign frame_bad_o = check_i & ~inv_ok;

endmodule

// File: rtl/ir_led_cmd_ctrl.sv
// IR LED command engine: validates NEC frames and applies decoded actions to an LED bank.
// Build option IR_ADDR_FILTER_EN enables address filtering against DEV_ADDR.
module ir_led_cmd_ctrl
    import ir_cmd_pkg::*;
#(
    parameter int         LED_W     = 18,
    parameter logic [7:0] CODE_SHR  = DEF_CODE_SHR,
    parameter logic [7:0] CODE_SHL  = DEF_CODE_SHL,
    parameter logic [7:0] CODE_INV  = DEF_CODE_INV,
    parameter logic [7:0] CODE_SWAP = DEF_CODE_SWAP,
    parameter logic [7:0] CODE_ROR  = DEF_CODE_ROR,
    parameter logic [7:0] CODE_CLR  = DEF_CODE_CLR,
    parameter logic [7:0] DEV_ADDR  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_ready_i,
    input  logic [31:0]      ir_data_i,
    output logic [LED_W-1:0] led_o,
    output logic [7:0]       last_cmd_o,
    output logic [7:0]       cnt_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam codes_t CODES = '{shr: CODE_SHR, shl: CODE_SHL, inv: CODE_INV,
                                 ror: CODE_ROR, swp: CODE_SWAP, clr: CODE_CLR};

    state_e           state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] save_q, save_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             start;
    logic             frame_ok;
    logic             frame_bad;
    logic [7:0]       cmd;
    led_save_t        nxt;

    ir_frame_check #(
        .DEV_ADDR (DEV_ADDR)
    ) u_check (
        .clk         (clk),
        .rst         (rst),
        .ir_ready_i  (ir_ready_i),
        .ir_data_i   (ir_data_i),
        .capture_i   (state_q == IDLE),
        .check_i     (state_q == CHECK),
        .start_o     (start),
        .frame_ok_o  (frame_ok),
        .frame_bad_o (frame_bad),
        .cmd_o       (cmd)
    );

    assign nxt = led_next(CODES, LED_W, cmd, 32'(led_q), 32'(save_q));

    generate
        if (LED_W < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{nxt.led[31:LED_W], nxt.save[31:LED_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            led_q   <= '0;
            save_q  <= '0;
            last_q  <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            save_q  <= save_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Unrecognised codes still count and update last_cmd; only the LED action is skipped.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        save_d  = save_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                if (frame_ok) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                    if (frame_bad) err_d = 1'b1;
                end
            end
            EXEC: begin
                led_d   = nxt.led[LED_W-1:0];
                save_d  = nxt.save[LED_W-1:0];
                last_d  = cmd;
                cnt_d   = cnt_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign led_o      = led_q;
    assign last_cmd_o = last_q;
    assign cnt_o      = cnt_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q != IDLE);

endmodule
